// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Shares one SDRAM controller between two write ports (photon-count channel
//   writers 0/1) and one read port (host readout). The winner's address and
//   write data are latched at grant and held on the controller call lines until
//   the matching i_done bit arrives. The winner then gets a one-cycle done pulse,
//   and read data is returned on rd_data.
//
//   Ports
//     clk, rst_n                     clock, asynchronous active-low reset
//     wrN_req/addr/data (N=0,1)      write requests, held until wrN_done
//     wrN_gnt, wrN_done              port owns SDRAM / completion pulse
//     rd_req, rd_addr                read request, held until rd_done
//     rd_gnt, rd_done, rd_data       read grant / pulse / captured word
//     o_call[1:0]                    [1] write, [0] read; level, one-hot or zero
//     i_done[1:0]                    [1] write done, [0] read done
//     o_addr, o_wdata, i_rdata       controller address / write data / read data
//     o_busy                         state != IDLE
//     o_timeout_err                  sticky abort flag
//
//   Build option: define SDRAM_ARB_TIMEOUT_EN to abort a call after TIMEOUT
//   cycles without a matching i_done. When it is undefined, CALL waits forever.
//
//   state | meaning
//   IDLE  | no owner, pick a winner when any request is high
//   CALL  | o_call held, wait for the matching i_done
//   DONE  | done pulse high, gnt dropped on exit, forced idle gap
module sdram_port_arbiter #(
  parameter int ADDR_W        = 24,
  parameter int DATA_W        = 16,
  parameter int RD_STARVE_MAX = 4,
  parameter int TIMEOUT       = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr0_req,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  output logic              wr0_gnt,
  output logic              wr0_done,
  input  logic              wr1_req,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  output logic              wr1_gnt,
  output logic              wr1_done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_done,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        o_call,
  input  logic [1:0]        i_done,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_busy,
  output logic              o_timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_CALL, S_DONE} state_t;

  localparam int              SC_W   = $clog2(RD_STARVE_MAX + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(RD_STARVE_MAX);

  state_t            state_q, state_d;
  logic [2:0]        gnt_q, gnt_d;    // {rd, wr1, wr0}
  logic [2:0]        done_q, done_d;  // {rd, wr1, wr0}
  logic [1:0]        call_q, call_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              last_wr_q, last_wr_d;
  logic [SC_W-1:0]   starve_q, starve_d;

  logic any_req, any_wr, rd_win, wr_sel, call_hit, call_abort;

  assign any_wr  = wr0_req | wr1_req;
  assign any_req = any_wr | rd_req;
  assign rd_win  = rd_req && (!any_wr || (starve_q >= SC_MAX));
  // wr_sel=1 selects wr1; on a tie the port that did not win last time goes
  assign wr_sel  = (wr0_req && wr1_req) ? ~last_wr_q : wr1_req;
  assign call_hit = |(call_q & i_done);

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_q, to_d;
  logic            err_q, err_d;

  // counter starts at 0 on the grant edge, so o_call is high for TIMEOUT cycles
  assign call_abort = (state_q == S_CALL) && !call_hit && (to_q == TO_W'(TIMEOUT - 1));
  assign to_d       = (state_q == S_CALL) ? to_q + TO_W'(1) : '0;
  assign err_d      = err_q | call_abort;
  assign o_timeout_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      err_q <= err_d;
    end
  end
`else
  assign call_abort    = 1'b0;
  assign o_timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      done_q    <= '0;
      call_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      last_wr_q <= 1'b1;
      starve_q  <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      call_q    <= call_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      last_wr_q <= last_wr_d;
      starve_q  <= starve_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_CALL;
      S_CALL:  if (call_hit || call_abort) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_d     = gnt_q;
    done_d    = done_q;
    call_d    = call_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    last_wr_d = last_wr_q;
    starve_d  = rd_req ? starve_q : '0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          if (rd_win) begin
            gnt_d    = 3'b100;
            call_d   = 2'b01;
            addr_d   = rd_addr;
            starve_d = '0;
          end else begin
            call_d    = 2'b10;
            last_wr_d = wr_sel;
            if (wr_sel) begin
              gnt_d   = 3'b010;
              addr_d  = wr1_addr;
              wdata_d = wr1_data;
            end else begin
              gnt_d   = 3'b001;
              addr_d  = wr0_addr;
              wdata_d = wr0_data;
            end
            if (rd_req && (starve_q != SC_MAX)) starve_d = starve_q + SC_W'(1);
          end
        end
      end
      S_CALL: begin
        if (call_hit || call_abort) begin
          call_d = 2'b00;
          done_d = gnt_q;
          if (call_q[0] && i_done[0]) rdata_d = i_rdata;
        end
      end
      S_DONE: begin
        done_d = '0;
        gnt_d  = '0;
      end
      default: begin
        done_d = '0;
        gnt_d  = '0;
        call_d = '0;
      end
    endcase
  end

  assign wr0_gnt  = gnt_q[0];
  assign wr1_gnt  = gnt_q[1];
  assign rd_gnt   = gnt_q[2];
  assign wr0_done = done_q[0];
  assign wr1_done = done_q[1];
  assign rd_done  = done_q[2];
  assign rd_data  = rdata_q;
  assign o_call   = call_q;
  assign o_addr   = addr_q;
  assign o_wdata  = wdata_q;
  assign o_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr0_req = 1'b0, wr1_req = 1'b0, rd_req = 1'b0;
  logic [23:0] wr0_addr = '0, wr1_addr = '0, rd_addr = '0;
  logic [15:0] wr0_data = '0, wr1_data = '0;
  logic        wr0_gnt, wr1_gnt, rd_gnt, wr0_done, wr1_done, rd_done;
  logic [15:0] rd_data;
  logic [1:0]  o_call;
  logic [1:0]  i_done = '0;
  logic [23:0] o_addr;
  logic [15:0] o_wdata;
  logic [15:0] i_rdata = '0;
  logic        o_busy, o_timeout_err;

  sdram_port_arbiter #(
    .ADDR_W(24), .DATA_W(16), .RD_STARVE_MAX(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr0_req(wr0_req), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr0_gnt(wr0_gnt), .wr0_done(wr0_done),
    .wr1_req(wr1_req), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .wr1_gnt(wr1_gnt), .wr1_done(wr1_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_done(rd_done),
    .rd_data(rd_data), .o_call(o_call), .i_done(i_done), .o_addr(o_addr),
    .o_wdata(o_wdata), .i_rdata(i_rdata), .o_busy(o_busy),
    .o_timeout_err(o_timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;   // 0 = wr0, 1 = wr1, 2 = rd
    logic [23:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   cur_port = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input int port, input logic [23:0] addr, input logic [15:0] data);
    exp_t e;
    e.port = port;
    e.addr = addr;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    wr0_req = 1'b0; wr1_req = 1'b0; rd_req = 1'b0;
    i_done  = '0;   i_rdata = '0;
    sb.delete();
    @(negedge clk);
    chk("rst_call", o_call, 0);
    chk("rst_gnt", {rd_gnt, wr1_gnt, wr0_gnt}, 0);
    chk("rst_done", {rd_done, wr1_done, wr0_done}, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_rdata", rd_data, 0);
    chk("rst_terr", o_timeout_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // waits for o_call, pops the expected grant and compares it
  task automatic wait_grant();
    int   n = 0;
    int   got;
    exp_t e;
    while (o_call == 2'b00 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (o_call == 2'b00) begin
      chk("grant_wait_expired", 0, 1);
      return;
    end
    got = wr0_gnt ? 0 : wr1_gnt ? 1 : rd_gnt ? 2 : 3;
    if (sb.size() == 0) begin
      chk("sb_underflow", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk("gnt_port", got, e.port);
    chk("gnt_call", o_call, (e.port == 2) ? 32'd1 : 32'd2);
    chk("gnt_addr", o_addr, e.addr);
    if (e.port != 2) chk("gnt_wdata", o_wdata, e.data);
    chk("gnt_busy", o_busy, 1);
    cur_port = e.port;
  endtask

  task automatic complete(input int lat, input logic [15:0] rdat, input bit drop);
    repeat (lat) @(negedge clk);
    chk("call_held", o_call, (cur_port == 2) ? 32'd1 : 32'd2);
    chk("no_early_done", {rd_done, wr1_done, wr0_done}, 0);
    i_done  = (cur_port == 2) ? 2'b01 : 2'b10;
    i_rdata = rdat;
    @(negedge clk);
    i_done  = '0;
    i_rdata = 16'h0;
    chk("done_pulse", {rd_done, wr1_done, wr0_done}, 32'd1 << cur_port);
    chk("call_clr", o_call, 0);
    if (cur_port == 2) chk("rd_data", rd_data, rdat);
    if (drop) begin
      wr0_req = 1'b0; wr1_req = 1'b0; rd_req = 1'b0;
    end
    @(negedge clk);
    chk("done_clr", {rd_done, wr1_done, wr0_done}, 0);
    chk("gnt_clr", {rd_gnt, wr1_gnt, wr0_gnt}, 0);
    chk("busy_idle", o_busy, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // single write, 10-cycle controller latency, late input changes ignored
    do_reset();
    wr0_addr = 24'h000123; wr0_data = 16'hBEEF; wr0_req = 1'b1;
    push_exp(0, 24'h000123, 16'hBEEF);
    chk("t1_pre_call", o_call, 0);
    @(negedge clk);
    wait_grant();
    wr0_addr = 24'hFFFFFF; wr0_data = 16'h0000;
    repeat (4) @(negedge clk);
    chk("t1_addr_held", o_addr, 24'h000123);
    chk("t1_wdata_held", o_wdata, 16'hBEEF);
    complete(5, 16'h0, 1'b1);

    // two writers held continuously: strict alternation from reset
    do_reset();
    wr0_addr = 24'h000A00; wr0_data = 16'hA0A0;
    wr1_addr = 24'h000B00; wr1_data = 16'hB1B1;
    wr0_req = 1'b1; wr1_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) push_exp(0, 24'h000A00, 16'hA0A0);
      else            push_exp(1, 24'h000B00, 16'hB1B1);
    end
    for (int i = 0; i < 6; i++) begin
      wait_grant();
      complete(2 + i, 16'h0, (i == 5));
    end

    // read starvation bound: four writes then the read is forced
    do_reset();
    rd_addr = 24'h00CAFE;
    wr0_req = 1'b1; wr1_req = 1'b1; rd_req = 1'b1;
    push_exp(0, 24'h000A00, 16'hA0A0);
    push_exp(1, 24'h000B00, 16'hB1B1);
    push_exp(0, 24'h000A00, 16'hA0A0);
    push_exp(1, 24'h000B00, 16'hB1B1);
    push_exp(2, 24'h00CAFE, 16'h0);
    for (int i = 0; i < 5; i++) begin
      wait_grant();
      complete(3, (i == 4) ? 16'h5A5A : 16'h0, (i == 4));
    end
    repeat (3) @(negedge clk);
    chk("rd_data_hold", rd_data, 16'h5A5A);

    // read done bit during a write call is ignored
    do_reset();
    wr1_addr = 24'hABCDEF; wr1_data = 16'h1234; wr1_req = 1'b1;
    push_exp(1, 24'hABCDEF, 16'h1234);
    wait_grant();
    i_done = 2'b01; i_rdata = 16'h7777;
    repeat (3) @(negedge clk);
    chk("wrong_bit_call", o_call, 2'b10);
    chk("wrong_bit_done", {rd_done, wr1_done, wr0_done}, 0);
    chk("wrong_bit_rdata", rd_data, 16'h0);
    i_done = 2'b00;
    complete(1, 16'h0, 1'b1);

    // reset during CALL: immediate clear, no done, fresh grant afterwards
    do_reset();
    wr0_addr = 24'h000321; wr0_data = 16'h4242; wr0_req = 1'b1;
    push_exp(0, 24'h000321, 16'h4242);
    wait_grant();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_call", o_call, 0);
    chk("mid_rst_gnt", {rd_gnt, wr1_gnt, wr0_gnt}, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_addr", o_addr, 0);
    @(negedge clk);
    chk("mid_rst_done", {rd_done, wr1_done, wr0_done}, 0);
    rst_n = 1'b1;
    push_exp(0, 24'h000321, 16'h4242);
    wait_grant();
    complete(2, 16'h0, 1'b1);

`ifdef SDRAM_ARB_TIMEOUT_EN
    // controller never answers: abort after 16 cycles
    do_reset();
    wr0_req = 1'b1;
    push_exp(0, 24'h000321, 16'h4242);
    wait_grant();
    begin
      int n = 1;
      while (o_call != 2'b00 && n < 40) begin
        @(negedge clk);
        if (o_call != 2'b00) n++;
      end
      chk("to_call_cycles", n, 16);
    end
    chk("to_done", wr0_done, 1);
    chk("to_err", o_timeout_err, 1);
    chk("to_rdata", rd_data, 16'h0);
    wr0_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("to_err_sticky", o_timeout_err, 1);
    chk("to_busy", o_busy, 0);
`else
    // controller never answers: call is held with no abort
    do_reset();
    wr0_req = 1'b1;
    push_exp(0, 24'h000321, 16'h4242);
    wait_grant();
    repeat (30) @(negedge clk);
    chk("hang_call", o_call, 2'b10);
    chk("hang_done", {rd_done, wr1_done, wr0_done}, 0);
    chk("hang_terr", o_timeout_err, 0);
    complete(0, 16'h0, 1'b1);
`endif

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
